// File: rtl/eaglesong_sponge_absorb_if.sv
// Bus bundle for the Eaglesong sponge front-end: message stream in,
// permutation engine handshake, digest stream out.
interface eaglesong_sponge_absorb_if;
  logic [31:0]       msg_data;
  logic              msg_valid;
  logic              msg_last;
  logic [1:0]        msg_bytes;
  logic              msg_empty;
  logic              msg_ready;
  logic [15:0][31:0] perm_state_in;
  logic              perm_start;
  logic [15:0][31:0] perm_state_out;
  logic              perm_done;
  logic [7:0][31:0]  digest;
  logic              digest_valid;
  logic              digest_ready;

  modport slave (
    input  msg_data, msg_valid, msg_last, msg_bytes, msg_empty,
    output msg_ready,
    output perm_state_in, perm_start,
    input  perm_state_out, perm_done,
    output digest, digest_valid,
    input  digest_ready
  );

  modport master (
    output msg_data, msg_valid, msg_last, msg_bytes, msg_empty,
    input  msg_ready,
    input  perm_state_in, perm_start,
    output perm_state_out, perm_done,
    input  digest, digest_valid,
    output digest_ready
  );
endinterface

// File: rtl/eaglesong_sponge_absorb.sv
// Eaglesong sponge absorb: packs 32-bit words into rate blocks, pads, drives the
// permutation engine and presents the digest. EAGLESONG_SPONGE_CYCLE_COUNT_EN adds hash_cycles.
//
// state  | meaning
// IDLE   | clear sponge state and word index
// ABSORB | accept message words into the block buffer
// PAD    | zero unwritten words, set final rate bit, build overflow delimiter block
// LAUNCH | XOR block into state, pulse perm_start
// WAIT   | wait for perm_done (first cycle ignored)
// OUT    | hold digest until digest_ready
module eaglesong_sponge_absorb #(
  parameter logic [7:0] DELIM      = 8'h06,
  parameter int         RATE_WORDS = 8
) (
  input  logic clk,
  input  logic rst,
  eaglesong_sponge_absorb_if.slave bus
`ifdef EAGLESONG_SPONGE_CYCLE_COUNT_EN
  ,
  output logic [31:0] hash_cycles
`endif
);

  localparam int          IDX_W      = $clog2(RATE_WORDS);
  localparam logic [31:0] DELIM_WORD = {DELIM, 24'h000000};

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PAD, S_LAUNCH, S_WAIT, S_OUT
  } fsm_t;

  fsm_t                        fsm_q, fsm_d;
  logic [15:0][31:0]           state_q;
  logic [RATE_WORDS-1:0][31:0] blk_q, pad_blk;
  logic [RATE_WORDS-1:0]       wr_mask_q, pad_mask;
  logic [IDX_W-1:0]            idx_q, idx_nxt;
  logic                        final_q, pending_pad_q, wait_first_q;
  logic [7:0][31:0]            digest_q;
  logic                        hs, last_idx, perm_ok;
  logic [31:0]                 tail_word;

  assign hs       = bus.msg_valid && bus.msg_ready;
  assign idx_nxt  = idx_q + 1'b1;
  assign last_idx = (idx_q == IDX_W'(RATE_WORDS - 1));
  assign perm_ok  = (fsm_q == S_WAIT) && !wait_first_q && bus.perm_done;

  // Partial final word: keep the valid leading bytes, delimiter follows them.
  always_comb begin
    case (bus.msg_bytes)
      2'd1:    tail_word = {bus.msg_data[31:24], DELIM, 16'h0000};
      2'd2:    tail_word = {bus.msg_data[31:16], DELIM, 8'h00};
      2'd3:    tail_word = {bus.msg_data[31:8], DELIM};
      default: tail_word = bus.msg_data;
    endcase
  end

  always_comb begin
    pad_blk  = blk_q;
    pad_mask = wr_mask_q;
    if (pending_pad_q) begin
      pad_blk[0]  = DELIM_WORD;
      pad_mask[0] = 1'b1;
    end
    for (int i = 0; i < RATE_WORDS; i++) begin
      if (!pad_mask[i]) pad_blk[i] = '0;
    end
    pad_blk[RATE_WORDS-1] = pad_blk[RATE_WORDS-1] ^ 32'h0000_0080;
  end

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:   fsm_d = S_ABSORB;
      S_ABSORB: begin
        if (hs) begin
          if (bus.msg_empty || (bus.msg_last && bus.msg_bytes != 2'd0)) fsm_d = S_PAD;
          else if (last_idx)                                           fsm_d = S_LAUNCH;
          else if (bus.msg_last)                                       fsm_d = S_PAD;
        end
      end
      S_PAD:    fsm_d = S_LAUNCH;
      S_LAUNCH: fsm_d = S_WAIT;
      S_WAIT: begin
        if (perm_ok) begin
          if (pending_pad_q) fsm_d = S_PAD;
          else if (final_q)  fsm_d = S_OUT;
          else               fsm_d = S_ABSORB;
        end
      end
      S_OUT:    if (bus.digest_ready) fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.msg_ready     = (fsm_q == S_ABSORB);
    bus.perm_start    = (fsm_q == S_LAUNCH);
    bus.digest_valid  = (fsm_q == S_OUT);
    bus.perm_state_in = {state_q[15:RATE_WORDS], state_q[RATE_WORDS-1:0] ^ blk_q};
    bus.digest        = digest_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= '0;
      blk_q         <= '0;
      wr_mask_q     <= '0;
      idx_q         <= '0;
      final_q       <= 1'b0;
      pending_pad_q <= 1'b0;
      wait_first_q  <= 1'b0;
      digest_q      <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          state_q       <= '0;
          blk_q         <= '0;
          wr_mask_q     <= '0;
          idx_q         <= '0;
          final_q       <= 1'b0;
          pending_pad_q <= 1'b0;
        end
        S_ABSORB: begin
          if (hs) begin
            wr_mask_q[idx_q] <= 1'b1;
            if (bus.msg_empty) begin
              blk_q[idx_q] <= DELIM_WORD;
              final_q      <= 1'b1;
            end else if (bus.msg_last && bus.msg_bytes != 2'd0) begin
              blk_q[idx_q] <= tail_word;
              final_q      <= 1'b1;
            end else begin
              blk_q[idx_q] <= bus.msg_data;
              idx_q        <= idx_nxt;
              if (bus.msg_last) begin
                final_q <= 1'b1;
                // Full final word: the delimiter spills into the next word or block.
                if (last_idx) begin
                  pending_pad_q <= 1'b1;
                end else begin
                  blk_q[idx_nxt]     <= DELIM_WORD;
                  wr_mask_q[idx_nxt] <= 1'b1;
                end
              end
            end
          end
        end
        S_PAD: begin
          blk_q         <= pad_blk;
          pending_pad_q <= 1'b0;
        end
        S_LAUNCH: wait_first_q <= 1'b1;
        S_WAIT: begin
          wait_first_q <= 1'b0;
          if (perm_ok) begin
            state_q   <= bus.perm_state_out;
            blk_q     <= '0;
            wr_mask_q <= '0;
            if (final_q && !pending_pad_q) digest_q <= bus.perm_state_out[7:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EAGLESONG_SPONGE_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q;
  logic        cyc_run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q   <= '0;
      cyc_run_q   <= 1'b0;
      hash_cycles <= '0;
    end else begin
      if (fsm_q == S_IDLE) begin
        cyc_cnt_q <= '0;
        cyc_run_q <= 1'b0;
      end else if (hs && !cyc_run_q) begin
        cyc_cnt_q <= '0;
        cyc_run_q <= 1'b1;
      end else if (cyc_run_q && cyc_cnt_q != 32'hFFFF_FFFF) begin
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end
      if (perm_ok && fsm_d == S_OUT) begin
        hash_cycles <= (cyc_cnt_q == 32'hFFFF_FFFF) ? cyc_cnt_q : cyc_cnt_q + 32'd1;
        cyc_run_q   <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eaglesong_sponge_absorb.sv
// Bench for eaglesong_sponge_absorb: byte-level padding model plus a stub
// permutation engine; expected blocks and digests go through scoreboard queues.
module tb_eaglesong_sponge_absorb;
  typedef logic [15:0][31:0] st_t;
  typedef logic [7:0][31:0]  dg_t;
  typedef logic [7:0]        bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eaglesong_sponge_absorb_if bus();
`ifdef EAGLESONG_SPONGE_CYCLE_COUNT_EN
  logic [31:0] hash_cycles;
`endif

  eaglesong_sponge_absorb dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef EAGLESONG_SPONGE_CYCLE_COUNT_EN
    ,
    .hash_cycles(hash_cycles)
`endif
  );

  int  total = 0, bad = 0, cyc = 0;
  int  start_cnt = 0, last_start_cyc = 0, hs_cyc = 0, dv_cyc = 0;
  bit  stub_mode = 1'b0;
  st_t exp_perm_q[$];
  dg_t exp_dig_q[$];

  always @(posedge clk) cyc++;

  // Stub engine: identity or a word-rotating scramble.
  function automatic st_t stub_f(input st_t x);
    st_t r;
    r = x;
    if (stub_mode)
      for (int i = 0; i < 16; i++) r[i] = x[(i + 3) % 16] ^ (32'h9E37_79B9 * 32'(i + 1));
    return r;
  endfunction

  // 44-cycle latency; a stale perm_done lingers through the first WAIT cycle.
  task automatic stub_proc();
    int  scnt, shold;
    st_t scap;
    scnt = 0; shold = 0; scap = '0;
    bus.perm_done = 1'b0;
    bus.perm_state_out = '0;
    forever begin
      @(negedge clk);
      if (shold > 0) begin
        shold--;
        if (shold == 0) bus.perm_done = 1'b0;
      end
      if (bus.perm_start) begin
        scap  = stub_f(bus.perm_state_in);
        scnt  = 44;
        shold = 2;
      end else if (scnt > 0) begin
        scnt--;
        if (scnt == 0) begin
          bus.perm_state_out = scap;
          bus.perm_done = 1'b1;
        end
      end
    end
  endtask

  task automatic monitor_proc();
    st_t e;
    forever begin
      @(negedge clk);
      if (bus.perm_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        total++;
        if (exp_perm_q.size() == 0) begin
          bad++;
          $display("FAIL perm_block: unexpected perm_start, state_in %h", bus.perm_state_in);
        end else begin
          e = exp_perm_q.pop_front();
          if (bus.perm_state_in !== e) begin
            bad++;
            $display("FAIL perm_block: got %h want %h", bus.perm_state_in, e);
          end
        end
      end
    end
  endtask

  task automatic model_push(input bq_t m, output int nblk);
    bq_t p;
    st_t st;
    st = '0;
    p = m;
    p.push_back(8'h06);
    while (p.size() % 32 != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] ^ 8'h80;
    nblk = p.size() / 32;
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 8; w++)
        st[w] = st[w] ^ {p[32*b+4*w], p[32*b+4*w+1], p[32*b+4*w+2], p[32*b+4*w+3]};
      exp_perm_q.push_back(st);
      st = stub_f(st);
    end
    exp_dig_q.push_back(st[7:0]);
  endtask

  // Called #1 after a posedge; unused tail bytes carry 8'hA5 to exercise masking.
  task automatic send_msg(input bq_t m, output bit ok);
    int n, nw, budget;
    logic [31:0] w;
    n  = m.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    ok = 1'b1;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) w[31-8*j -: 8] = (4*k + j < n) ? m[4*k + j] : 8'hA5;
      bus.msg_data  = w;
      bus.msg_last  = (k == nw - 1);
      bus.msg_empty = (n == 0);
      bus.msg_bytes = (k == nw - 1) ? 2'(n % 4) : 2'd1;
      bus.msg_valid = 1'b1;
      budget = 400;
      while (!bus.msg_ready && budget > 0) begin
        @(posedge clk); #1;
        budget--;
      end
      if (budget == 0) begin
        total++; bad++;
        $display("FAIL msg_accept: word %0d msg_ready got 0 want 1", k);
        ok = 1'b0;
        break;
      end
      hs_cyc = cyc;
      @(posedge clk); #1;
    end
    bus.msg_valid = 1'b0;
    bus.msg_last  = 1'b0;
    bus.msg_empty = 1'b0;
  endtask

  task automatic run_hash(input bq_t m, input int hold);
    int  nblk, s0, budget;
    bit  ok;
    dg_t e, d0;
    model_push(m, nblk);
    s0 = start_cnt;
    send_msg(m, ok);
    budget = 1000;
    while (bus.digest_valid !== 1'b1 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    dv_cyc = cyc;
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL digest_wait: digest_valid got 0 want 1 (len %0d)", m.size());
    end
    e = (exp_dig_q.size() > 0) ? exp_dig_q.pop_front() : '1;
    total++;
    if (bus.digest !== e) begin
      bad++;
      $display("FAIL digest: len %0d got %h want %h", m.size(), bus.digest, e);
    end
    total++;
    if (start_cnt - s0 != nblk) begin
      bad++;
      $display("FAIL perm_starts: len %0d got %0d want %0d", m.size(), start_cnt - s0, nblk);
    end
    total++;
    if (exp_perm_q.size() != 0) begin
      bad++;
      $display("FAIL perm_left: got %0d outstanding want 0", exp_perm_q.size());
    end
    total++;
    if (bus.msg_ready !== 1'b0) begin
      bad++;
      $display("FAIL out_msg_ready: got %b want 0", bus.msg_ready);
    end
    d0 = bus.digest;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.digest_valid !== 1'b1 || bus.digest !== d0 || bus.msg_ready !== 1'b0) begin
        bad++;
        $display("FAIL digest_hold: cycle %0d valid %b ready %b digest %h want valid 1 ready 0 digest %h",
                 c, bus.digest_valid, bus.msg_ready, bus.digest, d0);
      end
    end
    bus.digest_ready = 1'b1;
    @(posedge clk); #1;
    bus.digest_ready = 1'b0;
    total++;
    if (bus.digest_valid !== 1'b0) begin
      bad++;
      $display("FAIL digest_release: digest_valid got %b want 0", bus.digest_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.msg_ready !== 1'b0)    begin bad++; $display("FAIL rst_msg_ready: got %b want 0", bus.msg_ready); end
    total++; if (bus.perm_start !== 1'b0)   begin bad++; $display("FAIL rst_perm_start: got %b want 0", bus.perm_start); end
    total++; if (bus.digest_valid !== 1'b0) begin bad++; $display("FAIL rst_digest_valid: got %b want 0", bus.digest_valid); end
    total++; if (bus.digest !== '0)         begin bad++; $display("FAIL rst_digest: got %h want 0", bus.digest); end
    total++; if (bus.perm_state_in !== '0)  begin bad++; $display("FAIL rst_state_in: got %h want 0", bus.perm_state_in); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    bq_t m;
    m = {};
    stub_mode = 1'b0;
    run_hash(m, 0);
    total++;
    if (dv_cyc - last_start_cyc != 45) begin
      bad++;
      $display("FAIL empty_latency: start->digest_valid got %0d want 45", dv_cyc - last_start_cyc);
    end
  endtask

  task automatic test_abc();
    bq_t m;
    m = '{8'h61, 8'h62, 8'h63};
    stub_mode = 1'b1;
    run_hash(m, 0);
    total++;
    if (last_start_cyc - hs_cyc != 2) begin
      bad++;
      $display("FAIL abc_latency: last handshake->perm_start got %0d want 2", last_start_cyc - hs_cyc);
    end
  endtask

  task automatic test_two_blocks();
    bq_t m;
    m = {};
    for (int k = 0; k < 8; k++) begin
      m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'h00); m.push_back(8'(k));
    end
    stub_mode = 1'b1;
    run_hash(m, 0);
  endtask

  task automatic test_31_bytes();
    bq_t m;
    m = {};
    for (int k = 0; k < 31; k++) m.push_back(8'($urandom_range(0, 255)));
    stub_mode = 1'b1;
    run_hash(m, 0);
  endtask

  task automatic test_lengths();
    int  lens[10];
    bq_t m;
    lens = '{1, 2, 4, 8, 28, 32, 33, 60, 64, 65};
    stub_mode = 1'b1;
    foreach (lens[i]) begin
      m = {};
      for (int k = 0; k < lens[i]; k++) m.push_back(8'($urandom_range(0, 255)));
      run_hash(m, 0);
    end
  endtask

  task automatic test_reset_mid_wait();
    bq_t m;
    int  nblk, s0, budget;
    bit  ok;
    m = '{8'h61, 8'h62, 8'h63};
    stub_mode = 1'b1;
    model_push(m, nblk);
    s0 = start_cnt;
    send_msg(m, ok);
    budget = 50;
    while (start_cnt == s0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL abort_start: perm_start count got %0d want %0d", start_cnt - s0, 1);
    end
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.msg_ready !== 1'b0)    begin bad++; $display("FAIL abort_msg_ready: got %b want 0", bus.msg_ready); end
    total++; if (bus.digest_valid !== 1'b0) begin bad++; $display("FAIL abort_digest_valid: got %b want 0", bus.digest_valid); end
    total++; if (bus.perm_start !== 1'b0)   begin bad++; $display("FAIL abort_perm_start: got %b want 0", bus.perm_start); end
    total++; if (bus.digest !== '0)         begin bad++; $display("FAIL abort_digest: got %h want 0", bus.digest); end
    rst = 1'b0;
    exp_perm_q.delete();
    exp_dig_q.delete();
    // Let the abandoned run finish so a stale perm_done is high before the next launch.
    repeat (40) @(posedge clk);
    #1;
    run_hash(m, 0);
  endtask

  task automatic test_digest_hold();
    bq_t m;
    m = {};
    for (int k = 0; k < 20; k++) m.push_back(8'($urandom_range(0, 255)));
    stub_mode = 1'b1;
    run_hash(m, 20);
  endtask

  initial begin
    bus.msg_data     = '0;
    bus.msg_valid    = 1'b0;
    bus.msg_last     = 1'b0;
    bus.msg_bytes    = 2'd0;
    bus.msg_empty    = 1'b0;
    bus.digest_ready = 1'b0;
    fork
      stub_proc();
      monitor_proc();
    join_none
    test_reset();
    test_empty();
    test_abc();
    test_two_blocks();
    test_31_bytes();
    test_lengths();
    test_reset_mid_wait();
    test_digest_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
